offset_decoder: RTL and testbench
=================================

OFFSET_DECODER -- requirements
Module: offset_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the accepted-word counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH, encoded word (plain value + INCREMENT, modulo 2^WIDTH).
REQ-006 SHALL have port in_valid, input, 1, in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, block accepts a word this cycle.
REQ-008 SHALL have port out_data, output, WIDTH, decoded word.
REQ-009 SHALL have port out_valid, output, 1, out_data is valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-011 SHALL have port word_count, output, CNT_WIDTH, number of words accepted on the input since reset.
REQ-012 SHALL have port out_borrow, output, 1, present only when OFFSET_DECODER_BORROW_EN is defined.

Function
REQ-013 SHALL decode as out = (in_data - INCREMENT) mod 2^WIDTH, with INCREMENT = 5 truncated to WIDTH bits (for example, 1 when WIDTH = 2).
REQ-014 SHALL register each input transfer (in_valid & in_ready) into a 2-entry FIFO of decoded words, so that latency from input transfer to out_valid is exactly 1 cycle.
REQ-015 SHALL implement the FIFO occupancy states EMPTY, ONE and TWO.
REQ-016 SHALL make the following occupancy transitions: push only +1; pop only -1; push and pop in the same cycle, no change.
REQ-017 SHALL drive in_ready = (state != TWO), combinationally from registered state only, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (state != EMPTY), with out_data equal to the oldest entry.
REQ-019 SHALL hold out_data and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL accept a simultaneous push and pop in state TWO as a pop only, because in_ready is 0.
REQ-021 SHALL accept a simultaneous push and pop in state ONE, leaving the state at ONE with the new word now oldest.
REQ-022 SHALL sustain a throughput of 1 word per cycle when out_ready is held at 1.
REQ-023 SHALL increment word_count by 1 per input transfer, wrapping from 2^CNT_WIDTH-1 to 0 without any flag.
REQ-024 SHALL ignore in_data when in_valid = 0; it may be X.

Reset
REQ-025 SHALL, while rst = 1, force state to EMPTY, out_valid to 0, word_count to 0, out_data to 0 and out_borrow to 0.
REQ-026 SHALL drop any input transfer presented in a reset cycle and SHALL NOT count it; in_ready is 0 during reset.
REQ-027 SHALL discard all buffered words on reset asserted mid-stream; the first cycle after reset deassertion is in state EMPTY.

Configuration
REQ-028 SHALL, with OFFSET_DECODER_BORROW_EN defined, store a borrow bit per FIFO entry (1 when in_data < INCREMENT, i.e. decode wrapped) and present it on out_borrow aligned with out_data.
REQ-029 SHALL, without OFFSET_DECODER_BORROW_EN, omit the out_borrow port and its storage, leaving all other behaviour identical.

Structure
REQ-030 SHALL take the INCREMENT constant (5) and the occupancy-state typedef (EMPTY/ONE/TWO) from shared package offset_pkg, which is also the source of the encoder's increment.
REQ-031 SHALL implement the storage as sub-module offset_fifo2, a parameterised-width 2-entry FIFO with valid/ready on both sides.
REQ-032 SHALL place the subtract, borrow generation and word_count in offset_decoder.

Verification
REQ-033 SHALL cover basic decode: WIDTH = 8, push 0x0A with out_ready = 1 -> next cycle out_valid = 1, out_data = 0x05, word_count = 1.
REQ-034 SHALL cover wrap: WIDTH = 8, push 0x02 -> out_data = 0xFD; with BORROW_EN, out_borrow = 1.
REQ-035 SHALL cover backpressure: out_ready = 0, push 0x10, 0x11, 0x12 -> in_ready falls after 2 accepts and 0x12 is held off; then out_ready = 1 -> outputs 0x0B, 0x0C, 0x0D in order with no loss.
REQ-036 SHALL cover streaming: in_valid = out_ready = 1 for 100 cycles with incrementing data -> 100 outputs at 1 per cycle, each equal to input - 5, and word_count = 100.
REQ-037 SHALL cover mid-stream reset: state TWO, assert rst for 1 cycle -> out_valid = 0, word_count = 0, and the buffered words are never output.
REQ-038 SHALL cover narrow width: WIDTH = 2, push 0 -> out_data = 3 (INCREMENT truncated to 1).

Source files
------------

// File: rtl/offset_pkg.sv
// Shared constants and occupancy type for the offset encoder/decoder pair.
// Used by offset_decoder (optional borrow output under OFFSET_DECODER_BORROW_EN).
package offset_pkg;

  localparam int unsigned INCREMENT = 5;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/offset_fifo2.sv
// Two-entry FIFO with valid/ready on both sides; head is always the oldest entry.
// Width is set by the parent (widened by one bit when OFFSET_DECODER_BORROW_EN is defined).
module offset_fifo2
  import offset_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready
);

  occ_state_e    r_state, w_state_next;
  logic [DW-1:0] r_head, r_tail;
  logic [DW-1:0] w_head_next, w_tail_next;
  logic          w_push, w_pop;

  // Outputs depend only on registered state and rst, never on i_ready.
  assign o_ready = ~rst & (r_state != StTwo);
  assign o_valid = ~rst & (r_state != StEmpty);
  assign o_data  = rst ? '0 : r_head;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StEmpty;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_next;
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_head_next  = r_head;
    w_tail_next  = r_tail;
    unique case (r_state)
      StEmpty: begin
        if (w_push) begin
          w_head_next  = i_data;
          w_state_next = StOne;
        end
      end
      StOne: begin
        if (w_push && w_pop) begin
          w_head_next = i_data;
        end else if (w_push) begin
          w_tail_next  = i_data;
          w_state_next = StTwo;
        end else if (w_pop) begin
          w_state_next = StEmpty;
        end
      end
      StTwo: begin
        if (w_pop) begin
          w_head_next  = r_tail;
          w_state_next = StOne;
        end
      end
      default: w_state_next = StEmpty;
    endcase
  end

endmodule

// File: rtl/offset_decoder.sv
// Subtracts INCREMENT from each accepted word and buffers it in a 2-entry FIFO.
// Define OFFSET_DECODER_BORROW_EN to add a per-word out_borrow flag.
module offset_decoder
  import offset_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] word_count
`ifdef OFFSET_DECODER_BORROW_EN
  ,
  output logic                 out_borrow
`endif
);

  localparam logic [WIDTH-1:0] IncW = WIDTH'(INCREMENT);

`ifdef OFFSET_DECODER_BORROW_EN
  localparam int unsigned FifoW = WIDTH + 1;
`else
  localparam int unsigned FifoW = WIDTH;
`endif

  logic [WIDTH-1:0]     w_decoded;
  logic [FifoW-1:0]     w_fifo_in, w_fifo_out;
  logic                 w_xfer;
  logic [CNT_WIDTH-1:0] r_count;

  assign w_decoded = in_data - IncW;
  assign w_xfer    = in_valid & in_ready;

`ifdef OFFSET_DECODER_BORROW_EN
  // Borrow marks words whose decode wrapped below zero.
  assign w_fifo_in  = {(in_data < IncW), w_decoded};
  assign out_data   = w_fifo_out[WIDTH-1:0];
  assign out_borrow = w_fifo_out[WIDTH];
`else
  assign w_fifo_in = w_decoded;
  assign out_data  = w_fifo_out;
`endif

  offset_fifo2 #(
    .DW(FifoW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_data (w_fifo_in),
    .i_valid(in_valid),
    .o_ready(in_ready),
    .o_data (w_fifo_out),
    .o_valid(out_valid),
    .i_ready(out_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_xfer) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign word_count = rst ? '0 : r_count;

endmodule

// File: tb/tb_offset_decoder.sv
// Self-checking bench for offset_decoder: vector table, directed sequences, random traffic
// against a queue model, plus a narrow WIDTH=2 instance.
module tb_offset_decoder;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [CW-1:0] word_count;
`ifdef OFFSET_DECODER_BORROW_EN
  logic          out_borrow;
`endif

  logic       n_rst, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [1:0] n_in_data, n_out_data;
  logic [2:0] n_word_count;
`ifdef OFFSET_DECODER_BORROW_EN
  logic       n_out_borrow;
`endif

  offset_decoder #(
    .WIDTH    (W),
    .CNT_WIDTH(CW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_count(word_count)
`ifdef OFFSET_DECODER_BORROW_EN
    ,
    .out_borrow(out_borrow)
`endif
  );

  offset_decoder #(
    .WIDTH    (2),
    .CNT_WIDTH(3)
  ) u_dut_narrow (
    .clk       (clk),
    .rst       (n_rst),
    .in_data   (n_in_data),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .out_data  (n_out_data),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .word_count(n_word_count)
`ifdef OFFSET_DECODER_BORROW_EN
    ,
    .out_borrow(n_out_borrow)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of decoded words, accepted-word count, popped-word count.
  logic [W-1:0] q[$];
  logic         bq[$];
  int unsigned  m_count = 0;
  int unsigned  n_out   = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic       borrow;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_decode(input int unsigned d);
    return 8'((d + 256 - 5) % 256);
  endfunction

  // Inputs are driven just after a rising edge; check, then advance one cycle with the model.
  task automatic step();
    logic m_ready, m_valid, acc_in, acc_out;
    #1;
    m_ready = !rst && (q.size() < 2);
    m_valid = !rst && (q.size() > 0);
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, m_valid);
    chk("word_count", word_count, rst ? 0 : (m_count % 65536));
    if (rst) chk("rst_out_data", out_data, 0);
    if (m_valid) begin
      chk("out_data", out_data, q[0]);
`ifdef OFFSET_DECODER_BORROW_EN
      chk("out_borrow", out_borrow, bq[0]);
`endif
    end
    acc_in  = in_valid && m_ready;
    acc_out = out_ready && m_valid;
    @(posedge clk);
    if (rst) begin
      q.delete();
      bq.delete();
      m_count = 0;
    end else begin
      if (acc_out) begin
        q.delete(0);
        bq.delete(0);
        n_out++;
      end
      if (acc_in) begin
        q.push_back(ref_decode(in_data));
        bq.push_back(in_data < 5);
        m_count++;
      end
    end
    #1;
  endtask

  initial begin
    vecs[0] = '{din: 8'h0A, dout: 8'h05, borrow: 1'b0};
    vecs[1] = '{din: 8'h02, dout: 8'hFD, borrow: 1'b1};
    vecs[2] = '{din: 8'h05, dout: 8'h00, borrow: 1'b0};
    vecs[3] = '{din: 8'h04, dout: 8'hFF, borrow: 1'b1};
    vecs[4] = '{din: 8'h00, dout: 8'hFB, borrow: 1'b1};
    vecs[5] = '{din: 8'hFF, dout: 8'hFA, borrow: 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    n_rst = 1'b1; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
    @(posedge clk); #1;
    step();
    // Transfer offered during reset is dropped and not counted.
    in_valid = 1'b1; in_data = 8'h33;
    step();
    in_valid = 1'b0; rst = 1'b0; n_rst = 1'b0;
    step();

    // Single-word decode table.
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_data = vecs[i].din; out_ready = 1'b1;
      step();
      in_valid = 1'b0; in_data = 'x;
      chk("tbl_valid", out_valid, 1);
      chk("tbl_data", out_data, vecs[i].dout);
`ifdef OFFSET_DECODER_BORROW_EN
      chk("tbl_borrow", out_borrow, vecs[i].borrow);
`endif
      if (i == 0) chk("basic_count", word_count, 1);
      step();
    end

    // Backpressure: third word held off until the consumer drains.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h10; step();
    in_data = 8'h11; step();
    in_data = 8'h12; step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_data, 8'h0B);
    step();
    chk("bp_head_hold", out_data, 8'h0B);
    out_ready = 1'b1;
    step();
    chk("bp_head2", out_data, 8'h0C);
    step();
    in_valid = 1'b0; in_data = 'x;
    chk("bp_head3", out_data, 8'h0D);
    step();
    step();
    chk("bp_drained", out_valid, 0);

    // Streaming: 100 words at full rate.
    rst = 1'b1; step(); rst = 1'b0;
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = W'(i + 20); out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0; in_data = 'x;
    step();
    chk("stream_count", word_count, 100);
    chk("stream_outputs", n_out, 100);

    // Mid-stream reset while full.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h40; step();
    in_data = 8'h41; step();
    chk("mid_full", in_ready, 0);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", word_count, 0);
    repeat (3) step();

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = in_valid ? W'($urandom) : 'x;
      out_ready = ($urandom_range(2) != 0);
      rst       = ($urandom_range(49) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Narrow instance: INCREMENT truncates to 1, counter wraps after 8 words.
    n_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_in_valid = 1'b1; n_in_data = 2'(k % 4);
      @(posedge clk); #1;
      n_in_valid = 1'b0; n_in_data = '0;
      #1;
      chk("narrow_valid", n_out_valid, 1);
      chk("narrow_data", n_out_data, ((k % 4) + 3) % 4);
      chk("narrow_count", n_word_count, (k + 1) % 8);
`ifdef OFFSET_DECODER_BORROW_EN
      chk("narrow_borrow", n_out_borrow, (k % 4) == 0);
`endif
      @(posedge clk); #1;
      chk("narrow_empty", n_out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
